// File: rtl/ifu_prefetch_if.sv
// Fetch-unit bus bundle: memory request/response channels, decoder-facing
// instruction channel, redirect port and the busy flag.
// "master" is the fetch unit's view, "slave" is the surrounding system's view.
interface ifu_prefetch_if #(
  parameter int XLEN = 64,
  parameter int IW   = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [IW-1:0]   inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc, busy,
    input  req_ready, rsp_valid, rsp_data, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc, busy,
    output req_ready, rsp_valid, rsp_data, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with a prefetch queue.
// Requests go out on a valid/ready channel; responses come back in order with
// any latency >= 1 and no backpressure, so a request is only issued when a
// queue slot is guaranteed for its response (credit = queued + in flight).
// A redirect flushes the queue and turns every in-flight request into one that
// must be discarded when its response arrives.
module ifu_prefetch #(
  parameter int          XLEN   = 64,
  parameter int          IW     = 32,
  parameter int          DEPTH  = 2,
  parameter logic [63:0] PC_RST = 64'h8000_0000
) (
  input logic           clk,
  input logic           rst,
  ifu_prefetch_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [XLEN-1:0] PC_INIT      = PC_RST[XLEN-1:0];
  localparam logic [CW+1:0]   CREDIT_LIMIT = (CW + 2)'(DEPTH);

  // Architectural fetch address
  logic [XLEN-1:0] fetch_pc;

  // Requests accepted by memory whose response is still owed, split into
  // live ones (outstanding) and ones made stale by a redirect (discard)
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  // In-flight PC FIFO: address of every accepted request, oldest at f_head
  logic [XLEN-1:0] f_pc [DEPTH];
  logic [PW-1:0]   f_head;
  logic [PW-1:0]   f_tail;

  // Instruction queue presented to the decoder
  logic [IW-1:0]   q_data [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [PW-1:0]   q_head;
  logic [PW-1:0]   q_tail;
  logic [CW-1:0]   q_count;

  // Per-cycle control decisions
  logic          in_flight;
  logic [CW+1:0] credit_used;
  logic          req_go;
  logic          hs;
  logic          redirect;
  logic          rsp_take;
  logic          rsp_live;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic          unused_redirect_low;

  // Decide this cycle's request, response and pop actions from registered state
  always_comb begin
    in_flight   = (outstanding != '0) || (discard != '0);
    credit_used = (CW + 2)'(q_count) + (CW + 2)'(outstanding) + (CW + 2)'(discard);
    req_go      = credit_used < CREDIT_LIMIT;
    hs          = req_go && bus.req_ready;
    redirect    = bus.redirect_valid;
    rsp_take    = bus.rsp_valid && in_flight;
    rsp_drop    = rsp_take && (discard != '0);
    rsp_live    = rsp_take && (discard == '0);
    push        = rsp_live && !redirect;
    pop         = (q_count != '0) && bus.inst_ready && !redirect;
  end

  assign bus.req_valid  = req_go;
  assign bus.req_addr   = fetch_pc;
  assign bus.inst_valid = (q_count != '0);
  assign bus.inst       = q_data[q_head];
  assign bus.inst_pc    = q_pc[q_head];
  assign bus.busy       = in_flight;

  // The low two redirect bits are forced to zero and never looked at
  assign unused_redirect_low = &{1'b0, bus.redirect_pc[1:0]};

  // Fetch PC: redirect wins, otherwise step one word per accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= PC_INIT;
    end else if (redirect) begin
      fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
    end else if (hs) begin
      fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  // Response accounting: a redirect moves every owed response, including one
  // issued this very cycle, into the discard count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      outstanding <= '0;
      discard     <= discard + outstanding + CW'(hs) - CW'(rsp_take);
    end else begin
      outstanding <= outstanding + CW'(hs) - CW'(rsp_live);
      discard     <= discard - CW'(rsp_drop);
    end
  end

  // In-flight FIFO pointers keep draining across redirects so stale entries line up with their responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_head <= '0;
      f_tail <= '0;
    end else begin
      if (hs) begin
        f_tail <= f_tail + PW'(1);
      end
      if (rsp_take) begin
        f_head <= f_head + PW'(1);
      end
    end
  end

  // Instruction queue pointers and occupancy; a redirect empties it and voids a same-cycle pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
    end else if (redirect) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
    end else begin
      if (push) begin
        q_tail <= q_tail + PW'(1);
      end
      if (pop) begin
        q_head <= q_head + PW'(1);
      end
      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

  // Storage arrays need no reset: pointers and counters decide what is valid
  always_ff @(posedge clk) begin
    if (hs) begin
      f_pc[f_tail] <= fetch_pc;
    end
    if (push) begin
      q_data[q_tail] <= bus.rsp_data;
      q_pc[q_tail]   <= f_pc[f_head];
    end
  end

  // A response with nothing owed is a memory-side protocol violation; the logic above ignores it
  rsp_without_request: assert property (
    @(posedge clk) disable iff (rst)
      bus.rsp_valid |-> in_flight
  );

  // Queued plus owed entries can never exceed the number of queue slots
  credit_bound: assert property (
    @(posedge clk) disable iff (rst)
      credit_used <= CREDIT_LIMIT
  );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomised scoreboard bench for ifu_prefetch.
// The reference model tracks an epoch number per redirect: memory requests are
// tagged with the epoch they were issued in, and only responses whose epoch is
// still current land in the expected instruction queue.
module tb_ifu_prefetch;

  localparam int          XLEN   = 64;
  localparam int          IW     = 32;
  localparam int          DEPTH  = 4;
  localparam logic [63:0] PC_RST = 64'h8000_0000;

  typedef struct {
    logic [XLEN-1:0] addr;
    int              epoch;
    int              due;
  } mem_t;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [IW-1:0]   data;
  } inst_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ifu_prefetch_if #(.XLEN(XLEN), .IW(IW)) bus ();

  ifu_prefetch #(
    .XLEN  (XLEN),
    .IW    (IW),
    .DEPTH (DEPTH),
    .PC_RST(PC_RST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model state
  mem_t            mem_q[$];
  inst_t           deliv_q[$];
  logic [XLEN-1:0] model_pc;
  int              epoch;
  int              cyc;
  int              hs_count;
  bit              monitor_on;

  // Stimulus knobs
  int              p_req_ready;
  int              p_inst_ready;
  int              p_redirect;
  int              lat_min;
  int              lat_max;
  bit              force_redirect;
  logic [XLEN-1:0] forced_pc;

  int checks;
  int errors;

  // Monitor scratch
  int    pending;
  bit    exp_rv;
  bit    mon_hs;
  bit    mon_redir;
  mem_t  m_head;
  mem_t  m_new;
  inst_t i_new;

  function automatic logic [IW-1:0] mem_word(input logic [XLEN-1:0] a);
    logic [31:0] h;
    h = a[31:0] * 32'h9E37_79B1;
    return h ^ a[63:32] ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [XLEN-1:0] random_pc();
    if ($urandom_range(9) == 0) begin
      return {$urandom, $urandom};
    end
    return {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic clearModel();
    mem_q.delete();
    deliv_q.delete();
    model_pc = PC_RST[XLEN-1:0];
    epoch++;
    hs_count = 0;
  endtask

  task automatic zeroInputs();
    bus.req_ready      = 1'b0;
    bus.rsp_valid      = 1'b0;
    bus.rsp_data       = '0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_valid"}, bus.req_valid, 1);
    checkOutput({tag, "_req_addr"}, bus.req_addr, PC_RST);
    checkOutput({tag, "_inst_valid"}, bus.inst_valid, 0);
    checkOutput({tag, "_busy"}, bus.busy, 0);
  endtask

  // Assert rst between clock edges and check outputs before any edge arrives
  task automatic assertReset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    monitor_on = 1'b0;
    #1;
    checkResetOutputs("async_rst");
    zeroInputs();
    clearModel();
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    monitor_on = 1'b1;
  endtask

  task automatic applyStimulus(input int n_cycles);
    for (int i = 0; i < n_cycles; i++) begin
      @(posedge clk);
      #1;
      bus.req_ready  = (int'($urandom_range(99)) < p_req_ready);
      bus.inst_ready = (int'($urandom_range(99)) < p_inst_ready);
      if (force_redirect) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = forced_pc;
        force_redirect     = 1'b0;
      end else begin
        bus.redirect_valid = (int'($urandom_range(99)) < p_redirect);
        bus.redirect_pc    = random_pc();
      end
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = mem_word(mem_q[0].addr);
      end else begin
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = $urandom;
      end
    end
  endtask

  task automatic setKnobs(input int rr, input int ir, input int rd, input int lmin, input int lmax);
    p_req_ready  = rr;
    p_inst_ready = ir;
    p_redirect   = rd;
    lat_min      = lmin;
    lat_max      = lmax;
  endtask

  // Monitor: compare DUT outputs with the model, then advance model and memory
  always @(negedge clk) begin
    if (!rst && monitor_on) begin
      pending = mem_q.size();
      exp_rv  = (deliv_q.size() + pending) < DEPTH;
      checkOutput("req_valid", bus.req_valid, exp_rv);
      checkOutput("req_addr", bus.req_addr, model_pc);
      checkOutput("busy", bus.busy, pending != 0);
      checkOutput("inst_valid", bus.inst_valid, deliv_q.size() != 0);
      if (deliv_q.size() != 0) begin
        checkOutput("inst", bus.inst, deliv_q[0].data);
        checkOutput("inst_pc", bus.inst_pc, deliv_q[0].pc);
      end

      mon_hs    = bus.req_valid && bus.req_ready;
      mon_redir = bus.redirect_valid;

      if (deliv_q.size() != 0 && bus.inst_ready && !mon_redir) begin
        void'(deliv_q.pop_front());
      end
      if (bus.rsp_valid && mem_q.size() != 0) begin
        m_head = mem_q.pop_front();
        if (m_head.epoch == epoch && !mon_redir) begin
          i_new.pc   = m_head.addr;
          i_new.data = mem_word(m_head.addr);
          deliv_q.push_back(i_new);
        end
      end
      if (mon_hs) begin
        hs_count++;
        m_new.addr  = bus.req_addr;
        m_new.epoch = epoch;
        m_new.due   = cyc + int'($urandom_range(lat_max, lat_min));
        mem_q.push_back(m_new);
      end
      if (mon_redir) begin
        deliv_q.delete();
        epoch++;
        model_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
      end else if (mon_hs) begin
        model_pc = model_pc + XLEN'(4);
      end
    end
    cyc++;
  end

  // Hard time limit so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    cyc            = 0;
    epoch          = 0;
    monitor_on     = 1'b0;
    force_redirect = 1'b0;
    forced_pc      = '0;
    setKnobs(0, 0, 0, 1, 1);
    zeroInputs();
    clearModel();

    // Power-on reset
    #1 rst = 1'b1;
    #1 checkResetOutputs("por");
    releaseReset();

    // Single-cycle memory, decoder always ready: sequential fetch from PC_RST
    setKnobs(100, 100, 0, 1, 1);
    applyStimulus(20);

    // Decoder stalled: exactly DEPTH handshakes, then fetch stops
    assertReset();
    releaseReset();
    setKnobs(100, 0, 0, 1, 1);
    applyStimulus(10);
    checkOutput("fill_handshakes", hs_count, DEPTH);
    checkOutput("fill_req_valid", bus.req_valid, 0);
    setKnobs(100, 100, 0, 1, 1);
    applyStimulus(10);

    // Latency 3 with requests in flight, redirect to a misaligned target
    assertReset();
    releaseReset();
    setKnobs(100, 100, 0, 3, 3);
    applyStimulus(2);
    forced_pc      = 64'h8000_0103;
    force_redirect = 1'b1;
    applyStimulus(14);

    // Steady state with handshake, response and pop all landing with a redirect
    setKnobs(100, 100, 0, 1, 1);
    applyStimulus(8);
    forced_pc      = 64'h8000_0200;
    force_redirect = 1'b1;
    applyStimulus(8);

    // Address wrap at the top of the space
    forced_pc      = 64'hFFFF_FFFF_FFFF_FFFD;
    force_redirect = 1'b1;
    applyStimulus(8);

    // Random traffic, light and heavy redirect rates
    setKnobs(70, 60, 5, 1, 4);
    applyStimulus(3000);
    setKnobs(80, 80, 20, 1, 3);
    applyStimulus(2000);

    // Reset with entries queued and requests still owed
    setKnobs(100, 0, 0, 3, 3);
    applyStimulus(6);
    assertReset();
    releaseReset();
    setKnobs(100, 100, 0, 1, 2);
    applyStimulus(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
